cbus_arbiter: RTL and testbench

Single-master bus arbiter between the `riscv` core and memory. It merges the core's instruction bus (`ireq`/`iresp`) and data bus (`dreq`/`dresp`) into one single-beat core bus (`oreq`/`oresp`). Each request is latched at grant and held stable until the memory side completes it. Completion is reported as a one-cycle `addr_ok`/`data_ok` pulse to the granted port only.

---
 rtl/cbus_arbiter_if.sv | 75 +++++++
 rtl/cbus_arbiter.sv | 84 ++++++++
 tb/tb_cbus_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// Shared bus types plus the interface bundling the core-side instruction/data
// buses and the memory-side core bus.
// Ports: slave modport = arbiter view, master modport = core/memory view.
package cbus_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strobe_t;
    typedef logic [2:0]        msize_t;
    typedef logic [7:0]        mlen_t;
    typedef logic [1:0]        axi_burst_t;

    localparam msize_t     MSIZE4          = 3'd2;   // log2(bytes): 4-byte access
    localparam mlen_t      MLEN1           = 8'd0;   // AXI len encoding: beats - 1
    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic       valid;
        logic       is_write;
        msize_t     size;
        addr_t      addr;
        strobe_t    strobe;
        word_t      data;
        mlen_t      len;
        axi_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;
endpackage

interface cbus_arbiter_if;
    import cbus_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input  ireq, dreq, oresp, output iresp, dresp, oreq);
    modport master (output ireq, dreq, oresp, input  iresp, dresp, oreq);
endinterface

// File: rtl/cbus_arbiter.sv
// Merges the core's instruction and data buses onto one single-beat core bus, D over I.
// Latency: grant visible 1 cycle after request; completion pulse 1 cycle after ready&last.
// Backpressure: one transaction in flight; requesters hold valid until their data_ok pulse.
// Ports: clk, rst (async active-low), bus (slave modport: ireq/dreq/oresp in, iresp/dresp/oreq out).
module cbus_arbiter
    import cbus_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    cbus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {SEL_I, SEL_D} sel_t;

    state_t    state;
    sel_t      sel;
    cbus_req_t req;      // latched request; its valid bit is the oreq valid
    word_t     rdata;
    logic      i_ok;
    logic      d_ok;

    // Everything the memory side sees comes from the latch, never from live inputs.
    assign bus.oreq  = req;
    assign bus.iresp = '{addr_ok: i_ok, data_ok: i_ok, data: rdata};
    assign bus.dresp = '{addr_ok: d_ok, data_ok: d_ok, data: rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= SEL_I;
            req   <= '0;
            rdata <= '0;
            i_ok  <= 1'b0;
            d_ok  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The data side is the older instruction, so it wins ties.
                    if (bus.dreq.valid) begin
                        req <= '{valid:    1'b1,
                                 is_write: (bus.dreq.strobe != '0),
                                 size:     bus.dreq.size,
                                 addr:     bus.dreq.addr,
                                 strobe:   bus.dreq.strobe,
                                 data:     bus.dreq.data,
                                 len:      MLEN1,
                                 burst:    AXI_BURST_FIXED};
                        sel   <= SEL_D;
                        state <= BUSY;
                    end else if (bus.ireq.valid) begin
                        req <= '{valid:    1'b1,
                                 is_write: 1'b0,
                                 size:     MSIZE4,
                                 addr:     bus.ireq.addr,
                                 strobe:   '0,
                                 data:     '0,
                                 len:      MLEN1,
                                 burst:    AXI_BURST_FIXED};
                        sel   <= SEL_I;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready without last is not a legal single-beat reply: keep waiting.
                    if (bus.oresp.ready && bus.oresp.last) begin
                        rdata     <= bus.oresp.data;
                        req.valid <= 1'b0;
                        i_ok      <= (sel == SEL_I);
                        d_ok      <= (sel == SEL_D);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    i_ok  <= 1'b0;
                    d_ok  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic clk;
    logic rst;
    cbus_arbiter_if bus();

    cbus_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit      use_i, use_d, nolast, drop;
        addr_t   iaddr, daddr;
        msize_t  dsize;
        strobe_t dstrb;
        word_t   ddata;
        int      lat_a, lat_b;
        word_t   mem_a, mem_b;
        bit      exp_w;
        msize_t  exp_size;
        addr_t   exp_addr;
        strobe_t exp_strb;
        word_t   exp_data;
    } vec_t;

    typedef struct { int cyc; cbus_req_t req; } oev_t;
    typedef struct { int cyc; word_t data; } rev_t;

    int        n_cmp = 0;
    int        n_fail = 0;
    int        cyc = 0;
    oev_t      oq[$];
    rev_t      iq[$];
    rev_t      dq[$];
    int        mlat_q[$];
    word_t     mdat_q[$];
    bit        prev_valid = 1'b0;
    cbus_req_t snap;
    int        bcnt = 0;
    int        cur_lat = 0;
    word_t     cur_dat = '0;
    bit        mem_nolast = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe outputs away from the edge, then play the memory side.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("iresp_ok_pair", 256'(bus.iresp.addr_ok), 256'(bus.iresp.data_ok));
        chk("dresp_ok_pair", 256'(bus.dresp.addr_ok), 256'(bus.dresp.data_ok));
        chk("single_port_pulse", 256'(bus.iresp.data_ok & bus.dresp.data_ok), 256'(0));
        if (bus.oreq.valid && prev_valid)
            chk("oreq_stable", 256'(bus.oreq), 256'(snap));
        if (bus.oreq.valid && !prev_valid) begin
            snap = bus.oreq;
            oq.push_back('{cyc, bus.oreq});
        end
        prev_valid = bus.oreq.valid;
        if (bus.iresp.data_ok) iq.push_back('{cyc, bus.iresp.data});
        if (bus.dresp.data_ok) dq.push_back('{cyc, bus.dresp.data});

        // Memory: answers a request cur_lat cycles after it appears.
        bus.oresp = '0;
        if (!rst) begin
            bcnt = 0;
        end else if (bus.oreq.valid) begin
            if (bcnt == 0) begin
                cur_lat = (mlat_q.size() > 0) ? mlat_q.pop_front() : 0;
                cur_dat = (mdat_q.size() > 0) ? mdat_q.pop_front() : '0;
            end
            if (mem_nolast && bcnt == cur_lat)
                bus.oresp.ready = 1'b1;
            else if (bcnt == cur_lat + int'(mem_nolast))
                bus.oresp = '{ready: 1'b1, last: 1'b1, data: cur_dat};
            bcnt++;
        end else begin
            bcnt = 0;
        end
    endtask

    function automatic cbus_req_t i_req(input addr_t a);
        return '{valid: 1'b1, is_write: 1'b0, size: MSIZE4, addr: a, strobe: '0,
                 data: '0, len: MLEN1, burst: AXI_BURST_FIXED};
    endfunction

    // First transaction of a round follows directly from the priority and latch rules.
    function automatic vec_t ref_expect(input vec_t v);
        vec_t r = v;
        if (v.use_d) begin
            r.exp_w = (v.dstrb != 0); r.exp_size = v.dsize; r.exp_addr = v.daddr;
            r.exp_strb = v.dstrb;     r.exp_data = v.ddata;
        end else begin
            r.exp_w = 1'b0; r.exp_size = MSIZE4; r.exp_addr = v.iaddr;
            r.exp_strb = '0; r.exp_data = '0;
        end
        return r;
    endfunction

    task automatic run_round(input vec_t v, input string name);
        int        n = int'(v.use_i) + int'(v.use_d);
        int        t0, p1, g2;
        bit        ended = 1'b0;
        cbus_req_t e1;
        rev_t      first;
        oq.delete(); iq.delete(); dq.delete(); mlat_q.delete(); mdat_q.delete();
        mem_nolast = v.nolast;
        mlat_q.push_back(v.lat_a); mdat_q.push_back(v.mem_a);
        mlat_q.push_back(v.lat_b); mdat_q.push_back(v.mem_b);
        bus.ireq = '{valid: v.use_i, addr: v.iaddr};
        bus.dreq = '{valid: v.use_d, addr: v.daddr, size: v.dsize, strobe: v.dstrb, data: v.ddata};
        t0 = cyc;
        for (int k = 0; k < 300 && !ended; k++) begin
            tick();
            if (iq.size() > 0) bus.ireq.valid = 1'b0;
            if (dq.size() > 0) bus.dreq.valid = 1'b0;
            // Once granted, the live inputs no longer matter: scramble them.
            if (v.use_d && oq.size() >= 1) begin
                bus.dreq.addr = {$urandom, $urandom};
                bus.dreq.data = {$urandom, $urandom};
                bus.dreq.strobe = 8'($urandom);
                if (v.drop) bus.dreq.valid = 1'b0;
            end
            if (v.use_i && oq.size() == n) begin
                bus.ireq.addr = {$urandom, $urandom};
                if (v.drop) bus.ireq.valid = 1'b0;
            end
            if (iq.size() == int'(v.use_i) && dq.size() == int'(v.use_d)) ended = 1'b1;
        end
        chk({name, ".completed"}, 256'(ended), 256'(1));
        repeat (3) tick();
        bus.ireq = '0;
        bus.dreq = '0;
        chk({name, ".n_grants"}, 256'(oq.size()), 256'(n));
        chk({name, ".n_ipulse"}, 256'(iq.size()), 256'(v.use_i));
        chk({name, ".n_dpulse"}, 256'(dq.size()), 256'(v.use_d));
        if (oq.size() == n && iq.size() == int'(v.use_i) && dq.size() == int'(v.use_d)) begin
            e1 = '{valid: 1'b1, is_write: v.exp_w, size: v.exp_size, addr: v.exp_addr,
                   strobe: v.exp_strb, data: v.exp_data, len: MLEN1, burst: AXI_BURST_FIXED};
            chk({name, ".grant1_cyc"}, 256'(oq[0].cyc), 256'(t0 + 1));
            chk({name, ".grant1_req"}, 256'(oq[0].req), 256'(e1));
            first = v.use_d ? dq[0] : iq[0];
            p1 = t0 + 2 + v.lat_a + int'(v.nolast);
            chk({name, ".pulse1_cyc"}, 256'(first.cyc), 256'(p1));
            chk({name, ".pulse1_data"}, 256'(first.data), 256'(v.mem_a));
            if (n == 2) begin
                g2 = p1 + 2;
                chk({name, ".grant2_cyc"}, 256'(oq[1].cyc), 256'(g2));
                chk({name, ".grant2_req"}, 256'(oq[1].req), 256'(i_req(v.iaddr)));
                chk({name, ".pulse2_cyc"}, 256'(iq[0].cyc), 256'(g2 + 1 + v.lat_b + int'(v.nolast)));
                chk({name, ".pulse2_data"}, 256'(iq[0].data), 256'(v.mem_b));
            end
        end
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst = 1'b0;
        bus.ireq = '0;
        bus.dreq = '0;
        bus.oresp = '0;

        // Directed vectors: inputs, memory behaviour, and expected first request.
        v = '{default: 0}; v.use_i = 1; v.iaddr = 64'h8000_0000; v.lat_a = 3;
        v.mem_a = 64'h0000_0013_0000_0013;
        v.exp_size = MSIZE4; v.exp_addr = 64'h8000_0000; tbl.push_back(v);
        v = '{default: 0}; v.use_d = 1; v.daddr = 64'h8000_1000; v.dsize = 3'd2;
        v.dstrb = 8'h0F; v.ddata = 64'hDEAD_BEEF; v.lat_a = 1; v.mem_a = 64'h55;
        v.exp_w = 1; v.exp_size = 3'd2; v.exp_addr = 64'h8000_1000; v.exp_strb = 8'h0F;
        v.exp_data = 64'hDEAD_BEEF; tbl.push_back(v);
        v = '{default: 0}; v.use_i = 1; v.use_d = 1; v.iaddr = 64'h8000_0004;
        v.daddr = 64'h8000_2000; v.dsize = 3'd3; v.ddata = 64'h1234; v.lat_a = 0; v.lat_b = 2;
        v.mem_a = 64'hAAAA_0000_0000_0001; v.mem_b = 64'hBBBB_0000_0000_0002;
        v.exp_size = 3'd3; v.exp_addr = 64'h8000_2000; v.exp_data = 64'h1234; tbl.push_back(v);
        v = '{default: 0}; v.use_d = 1; v.nolast = 1; v.daddr = 64'h10; v.lat_a = 0;
        v.mem_a = 64'hFFFF_FFFF_FFFF_FFFF; v.exp_addr = 64'h10; tbl.push_back(v);
        v = '{default: 0}; v.use_i = 1; v.use_d = 1; v.nolast = 1; v.drop = 1;
        v.iaddr = 64'h8000_0040; v.daddr = 64'h8000_3008; v.dsize = 3'd3; v.dstrb = 8'hFF;
        v.ddata = 64'h0123_4567_89AB_CDEF; v.lat_a = 2; v.lat_b = 0; v.mem_a = 64'h1; v.mem_b = 64'h2;
        v.exp_w = 1; v.exp_size = 3'd3; v.exp_addr = 64'h8000_3008; v.exp_strb = 8'hFF;
        v.exp_data = 64'h0123_4567_89AB_CDEF; tbl.push_back(v);
        v = '{default: 0}; v.use_i = 1; v.drop = 1; v.iaddr = 64'hFFFF_FFFF_FFFF_FFFC;
        v.mem_a = 64'h0000_0000_0000_0073; v.exp_size = MSIZE4;
        v.exp_addr = 64'hFFFF_FFFF_FFFF_FFFC; tbl.push_back(v);

        // Reset state.
        tick();
        tick();
        chk("rst_oreq", 256'(bus.oreq), 256'(0));
        chk("rst_iresp", 256'(bus.iresp), 256'(0));
        chk("rst_dresp", 256'(bus.dresp), 256'(0));
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_valid", 256'(bus.oreq.valid), 256'(0));
            chk("idle_ok", 256'({bus.iresp.data_ok, bus.dresp.data_ok}), 256'(0));
        end

        for (int k = 0; k < tbl.size(); k++) run_round(tbl[k], $sformatf("vec%0d", k));

        // Asynchronous reset in the middle of a long transaction.
        mlat_q.delete(); mdat_q.delete();
        mlat_q.push_back(30); mdat_q.push_back(64'h99);
        mem_nolast = 1'b0;
        bus.ireq = '{valid: 1'b1, addr: 64'h8000_0100};
        repeat (3) tick();
        bus.ireq = '0;
        chk("pre_rst_busy", 256'(bus.oreq.valid), 256'(1));
        #2 rst = 1'b0;
        #1;
        chk("async_rst_oreq", 256'(bus.oreq), 256'(0));
        chk("async_rst_iresp", 256'(bus.iresp), 256'(0));
        chk("async_rst_dresp", 256'(bus.dresp), 256'(0));
        repeat (2) tick();
        rst = 1'b1;
        v = '{default: 0}; v.use_i = 1; v.iaddr = 64'h8000_0200; v.lat_a = 1; v.mem_a = 64'h77;
        run_round(ref_expect(v), "after_rst");

        // Randomized rounds against the transaction-level model.
        for (int r = 0; r < 40; r++) begin
            int kind = int'($urandom_range(2, 0));
            v = '{default: 0};
            v.use_i = (kind != 1);
            v.use_d = (kind != 0);
            v.iaddr = {$urandom, $urandom} & ~64'h3;
            v.daddr = {$urandom, $urandom};
            v.dsize = 3'($urandom_range(3, 0));
            v.dstrb = ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'h00;
            v.ddata = {$urandom, $urandom};
            v.lat_a = int'($urandom_range(5, 0));
            v.lat_b = int'($urandom_range(5, 0));
            v.mem_a = {$urandom, $urandom};
            v.mem_b = {$urandom, $urandom};
            v.nolast = ($urandom_range(3, 0) == 0);
            v.drop = ($urandom_range(1, 0) == 1);
            run_round(ref_expect(v), $sformatf("rnd%0d", r));
            repeat ($urandom_range(3, 0)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
